// File: rtl/fft_bitrev_reorder_if.sv
// ----------------------------------------------------------------------------
// fft_bitrev_reorder_if
//
// Purpose:
//   Groups the sample stream entering the bit-reversal reorder buffer and the
//   natural-order stream leaving it, so the reorder block and its neighbours
//   (or a testbench) connect through one bundle.
//
// Signals (names match the reorder block's port list):
//   valid_i     in-stream   sample strobe
//   data_in_r   in-stream   real part, signed, DW bits
//   data_in_i   in-stream   imag part, signed, DW bits
//   valid_o     out-stream  output strobe
//   data_out_r  out-stream  real part, natural order, signed, DW bits
//   data_out_i  out-stream  imag part, natural order, signed, DW bits
//   index_o     out-stream  natural-order bin index k (0..31)
//   last_o      out-stream  marks bin 31 of a frame
//
// Modports:
//   master  the side that feeds samples in and watches the reordered output
//   slave   the reorder block itself
// ----------------------------------------------------------------------------
interface fft_bitrev_reorder_if #(
    parameter int DW = 14
);

    logic                 valid_i;
    logic signed [DW-1:0] data_in_r;
    logic signed [DW-1:0] data_in_i;

    logic                 valid_o;
    logic signed [DW-1:0] data_out_r;
    logic signed [DW-1:0] data_out_i;
    logic        [4:0]    index_o;
    logic                 last_o;

    modport master (
        output valid_i,
        output data_in_r,
        output data_in_i,
        input  valid_o,
        input  data_out_r,
        input  data_out_i,
        input  index_o,
        input  last_o
    );

    modport slave (
        input  valid_i,
        input  data_in_r,
        input  data_in_i,
        output valid_o,
        output data_out_r,
        output data_out_i,
        output index_o,
        output last_o
    );

endinterface

// File: rtl/fft_bitrev_reorder.sv
// ----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Purpose:
//   Sits after the last butterfly stage of the 32-point pipelined FFT. That
//   stage delivers each frame in bit-reversed order; this block stores a whole
//   frame and replays it in natural order X[0]..X[31]. Two ping-pong banks let
//   one frame be written while the previous one is read, so a continuous input
//   stream yields a continuous output stream. Data is moved bit-exact.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        fft_bitrev_reorder_if.slave
//                valid_i / data_in_r / data_in_i        : bit-reversed input
//                valid_o / data_out_r / data_out_i      : natural-order output
//                index_o                                : bin index k
//                last_o                                 : high with k == 31
// ----------------------------------------------------------------------------
module fft_bitrev_reorder #(
    parameter int DW = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fft_bitrev_reorder_if.slave    bus
);

    localparam int N  = 32;
    localparam int AW = 5;

    typedef enum logic {
        RIDLE = 1'b0,
        RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_stateNext;

    logic [AW-1:0]     r_wcnt;
    logic              r_wbank;
    logic [1:0]        r_full;
    logic [1:0]        w_fullNext;
    logic              w_writeLast;

    logic [AW-1:0]     r_rcnt;
    logic [AW-1:0]     w_rcntNext;
    logic              r_rbank;
    logic              w_rbankNext;
    logic              w_otherBank;
    logic              w_running;
    logic              w_clearFull;
    logic [AW-1:0]     w_raddr;

    logic [2*DW-1:0]   r_mem [0:1][0:N-1];
    logic [2*DW-1:0]   w_rdata;

    logic              r_valid;
    logic              r_last;
    logic [DW-1:0]     r_dataR;
    logic [DW-1:0]     r_dataI;
    logic [AW-1:0]     r_index;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    assign w_writeLast = bus.valid_i && (r_wcnt == 5'd31);
    assign w_otherBank = ~r_rbank;
    assign w_running   = (r_state == RUN);

    // The stored frame is in bit-reversed order, so natural bin k lives at
    // address bitrev5(k).
    assign w_raddr = {r_rcnt[0], r_rcnt[1], r_rcnt[2], r_rcnt[3], r_rcnt[4]};
    assign w_rdata = r_mem[r_rbank][w_raddr];

    // ------------------------------------------------------------------
    // Frame buffer write port. Contents are deliberately left unreset; the
    // full flags decide whether anything stored is ever read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && bus.valid_i) begin
            r_mem[r_wbank][r_wcnt] <= {bus.data_in_r, bus.data_in_i};
        end
    end

    // ------------------------------------------------------------------
    // Write-side bookkeeping: sample counter and bank pointer. Gaps in
    // valid_i simply freeze the counter, so a frame is any 32 valid samples.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (bus.valid_i) begin
            r_wcnt <= r_wcnt + 5'd1;
            if (r_wcnt == 5'd31) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Full flags: the reader clears its bank as it emits bin 31; the writer
    // sets its bank as it stores sample 31. The set is applied last so it
    // wins if both ever touch the same bit on one edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_fullNext = r_full;
        if (w_clearFull) begin
            w_fullNext[r_rbank] = 1'b0;
        end
        if (w_writeLast) begin
            w_fullNext[r_wbank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_fullNext;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM state register together with the read counter and bank.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RIDLE;
            r_rcnt  <= '0;
            r_rbank <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_rcnt  <= w_rcntNext;
            r_rbank <= w_rbankNext;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM next-state logic. At the end of a frame the decision to keep
    // running looks at the registered full flag of the other bank; a bank
    // that fills on that very edge is only seen one cycle later, which costs
    // exactly one idle output cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_rcntNext  = r_rcnt;
        w_rbankNext = r_rbank;
        w_clearFull = 1'b0;

        case (r_state)
            RIDLE: begin
                if (r_full[r_rbank]) begin
                    w_stateNext = RUN;
                    w_rcntNext  = '0;
                end
            end

            RUN: begin
                w_rcntNext = r_rcnt + 5'd1;
                if (r_rcnt == 5'd31) begin
                    w_clearFull = 1'b1;
                    w_rbankNext = w_otherBank;
                    if (!r_full[w_otherBank]) begin
                        w_stateNext = RIDLE;
                    end
                end
            end

            default: begin
                w_stateNext = RIDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register. While running, every cycle emits one natural-order
    // bin; otherwise the strobes drop and the last data word is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_dataR <= '0;
            r_dataI <= '0;
            r_index <= '0;
        end else if (w_running) begin
            r_valid <= 1'b1;
            r_last  <= (r_rcnt == 5'd31);
            r_dataR <= w_rdata[2*DW-1:DW];
            r_dataI <= w_rdata[DW-1:0];
            r_index <= r_rcnt;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign bus.valid_o    = r_valid;
    assign bus.last_o     = r_last;
    assign bus.data_out_r = r_dataR;
    assign bus.data_out_i = r_dataI;
    assign bus.index_o    = r_index;

endmodule
